// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package imem_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int COUNT_W        = 16;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_e;

    // PC-style step to the next word-aligned byte address.
    function automatic logic [WORD_W-1:0] next_word_addr(input logic [WORD_W-1:0] addr);
        return addr + WORD_W'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface imem_loader_if;
    import imem_pkg::*;

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects accepted bytes little-endian into a 32-bit word and flags the
// cycle in which the last lane is being filled.
module imem_loader_word_assembler
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [IDX_W-1:0]  idx_r;
    logic [WORD_W-1:0] word_r;
    logic [4:0]        lane_lsb_s;

    assign lane_lsb_s = {idx_r, 3'b000};
    assign word_full  = accept && (idx_r == IDX_W'(BYTES_PER_WORD - 1));
    assign word       = word_r;

    // Lane insert and byte index; a new load restarts at lane 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r  <= {IDX_W{1'b0}};
            word_r <= {WORD_W{1'b0}};
        end else if (clr) begin
            idx_r  <= {IDX_W{1'b0}};
        end else if (accept) begin
            word_r[lane_lsb_s +: BYTE_W] <= byte_data;
            idx_r <= word_full ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial program into instruction memory, holding the CPU
// stalled until the requested number of words has been written.
module imem_loader
    import imem_pkg::*;
#(
    parameter int                DEPTH     = 256,
    parameter logic [WORD_W-1:0] BASE_ADDR = 32'h0000_0000
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] word_count,
    imem_loader_if.slave       bus,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [WORD_W-1:0]  checksum
);

    localparam logic [COUNT_W:0] DEPTH_L = (COUNT_W+1)'(DEPTH);

    state_e             state_r, state_nxt_s;
    logic [COUNT_W-1:0] remaining_r;
    logic [WORD_W-1:0]  addr_r, checksum_r, word_s;
    logic               byte_ready_r, mem_we_r, cpu_hold_r, done_r, error_r;
    logic               byte_ready_d_s, mem_we_d_s, cpu_hold_d_s;
    logic               accept_s, start_ok_s, oversize_s, word_full_s;

    assign accept_s   = bus.byte_valid && byte_ready_r;
    assign start_ok_s = (state_r == IDLE) && start;
    assign oversize_s = {1'b0, word_count} > DEPTH_L;

    imem_loader_word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_ok_s),
        .accept    (accept_s),
        .byte_data (bus.byte_data),
        .word      (word_s),
        .word_full (word_full_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!start)                      state_nxt_s = IDLE;
                else if (word_count == 16'd0)    state_nxt_s = FIN;
                else if (oversize_s)             state_nxt_s = IDLE;
                else                             state_nxt_s = RECV;
            end
            RECV: begin
                if (word_full_s) state_nxt_s = WRITE;
                else             state_nxt_s = RECV;
            end
            WRITE: begin
                if (remaining_r == 16'd1) state_nxt_s = FIN;
                else                      state_nxt_s = RECV;
            end
            FIN:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they can be registered.
    always_comb begin
        byte_ready_d_s = 1'b0;
        mem_we_d_s     = 1'b0;
        cpu_hold_d_s   = 1'b0;
        case (state_nxt_s)
            IDLE: begin
                cpu_hold_d_s   = 1'b0;
            end
            RECV: begin
                byte_ready_d_s = 1'b1;
                cpu_hold_d_s   = 1'b1;
            end
            WRITE: begin
                mem_we_d_s     = 1'b1;
                cpu_hold_d_s   = 1'b1;
            end
            FIN: begin
                cpu_hold_d_s   = 1'b1;
            end
            default: begin
                cpu_hold_d_s   = 1'b0;
            end
        endcase
    end

    // Registered control outputs and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ready_r <= 1'b0;
            mem_we_r     <= 1'b0;
            cpu_hold_r   <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            byte_ready_r <= byte_ready_d_s;
            mem_we_r     <= mem_we_d_s;
            cpu_hold_r   <= cpu_hold_d_s;
            if (state_nxt_s == FIN) done_r <= 1'b1;
            else if (start_ok_s)    done_r <= 1'b0;
            if (start_ok_s)         error_r <= oversize_s;
        end
    end

    // Address, word budget and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_r <= {COUNT_W{1'b0}};
            addr_r      <= BASE_ADDR;
            checksum_r  <= {WORD_W{1'b0}};
        end else if (start_ok_s) begin
            remaining_r <= word_count;
            addr_r      <= BASE_ADDR;
            checksum_r  <= {WORD_W{1'b0}};
        end else if (state_r == WRITE) begin
            remaining_r <= remaining_r - 16'd1;
            addr_r      <= next_word_addr(addr_r);
            checksum_r  <= checksum_r + word_s;
        end
    end

    assign bus.byte_ready = byte_ready_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_addr   = addr_r;
    assign bus.mem_wdata  = word_s;
    assign cpu_hold       = cpu_hold_r;
    assign done           = done_r;
    assign error          = error_r;
    assign checksum       = checksum_r;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart of the fetch/decode path: streams a program into instruction memory so the program counter and decoder later read valid words.
- Accepts a byte stream with a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to consecutive word-aligned byte addresses, keeps a running checksum, and holds the CPU in stall until loading completes.

Parameters:
- DEPTH, 256, instruction memory capacity in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be 4-aligned.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- word_count  input  16  number of words to load; latched when start is accepted.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  incoming program byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  32  byte address of the write (PC-style, steps of 4).
- mem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  high while a load is in progress; stalls the program counter.
- done  output  1  sticky; set when the last word is written, cleared by the next accepted start.
- error  output  1  sticky; set on an oversize request, cleared by the next accepted start.
- checksum  output  32  modulo-2^32 sum of all words written in the current load.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, done=0, error=0, checksum=0; byte index=0; remaining=0.
- States: IDLE, RECV, WRITE, FIN.
- IDLE:
  - start=1 clears done, error and checksum, latches word_count into remaining, and sets mem_addr=BASE_ADDR.
  - word_count=0 -> FIN with no writes.
  - word_count>DEPTH -> error=1, stay IDLE, no writes, cpu_hold stays 0.
  - Otherwise -> RECV.
- RECV:
  - byte_ready=1, cpu_hold=1.
  - A byte is accepted when byte_valid && byte_ready, and goes to lane [8*idx+7:8*idx] of the word register; idx increments 0..3.
  - The 4th accepted byte (idx=3) wraps idx to 0 -> WRITE.
  - byte_valid=0 stalls with no timeout.
- WRITE (one cycle):
  - byte_ready=0, mem_we=1, mem_wdata=assembled word, mem_addr=current address.
  - Next edge: checksum+=word, mem_addr+=4, remaining-=1; remaining becomes 0 -> FIN, else -> RECV.
- FIN (one cycle): done=1 (sticky), cpu_hold falls, then -> IDLE.
- Latency and throughput: write strobe the cycle after the 4th byte is accepted; peak throughput 1 word per 5 cycles.
- cpu_hold is high in RECV, WRITE and FIN. It is low in IDLE and in the first cycle after an error.
- mem_we is registered and never asserted outside WRITE.
- start is ignored outside IDLE.
- Bytes presented while byte_ready=0 are not consumed; the source must hold them.
- Reset mid-load aborts immediately, and words already written remain in memory. A partial word (idx≠0) is discarded.
- Address arithmetic: mem_addr is 32-bit unsigned. With word_count≤DEPTH, the last write is at BASE_ADDR+4*(word_count-1), so no wrap occurs.
- Checksum wraps modulo 2^32 silently.

Decomposition:
- Package imem_pkg holds:
  - state enum {IDLE, RECV, WRITE, FIN};
  - BYTES_PER_WORD=4, WORD_W=32, BYTE_W=8, COUNT_W=16.
- One natural sub-module: word_assembler. It contains the byte-lane shift/insert register and the idx counter, and emits a word_full pulse. The top holds the FSM, address, remaining counter and checksum.

Test Plan:
- Two-word load: start with word_count=2, then send bytes 13,05,A0,00 / 93,00,10,00 back-to-back. Expect mem_we pulses writing 0x00A00513 at 0x0 and 0x00100093 at 0x4; done=1; checksum=0x00B005A6; cpu_hold low after FIN.
- Stalled source: single word 0xDEADBEEF with byte_valid low for 3 cycles between bytes. Expect exactly one write of 0xDEADBEEF at 0x0, and no byte consumed while byte_valid=0.
- Boundary counts:
  - word_count=0 -> done=1 within 2 cycles, mem_we never asserted.
  - word_count=257 (DEPTH=256) -> error=1, no writes, cpu_hold stays 0.
  - start pulsed during RECV -> ignored, load completes normally.
- Reset mid-operation: rst_n low after 2 of 4 bytes of word 3 in a 5-word load. Expect all outputs at reset values asynchronously. A new load of 1 word 0x00000013 then writes at BASE_ADDR=0x0 with checksum=0x13.
- Full depth and wrap: load 256 words of 0xFFFFFFFF. Expect last write at 0x3FC, checksum=0xFFFFFF00 (modulo wrap), done=1.
